stopwatch_ctrl: RTL

Run/pause/clear controller for the team's modulo digit counters. It takes button-style command pulses and sequences a prescaled two-digit count (ones digit mod ONES_MAX+1, tens digit mod TENS_MAX+1). Counting stops with DONE at the terminal value. It sits between the debounced push-button logic and the 7-segment display drivers on the FPGA board.

---
 rtl/stopwatch_ctrl_if.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Command and display bundle for the stopwatch controller.
// Commands flow in from the button logic; digits and status flow out.
interface stopwatch_ctrl_if;
  logic       START;
  logic       STOP;
  logic       CLEAR;
  logic [3:0] ONES;
  logic [3:0] TENS;
  logic       RUNNING;
  logic       DONE;
  logic       TICK;

  modport master (
    output START, STOP, CLEAR,
    input  ONES, TENS, RUNNING, DONE, TICK
  );

  modport slave (
    input  START, STOP, CLEAR,
    output ONES, TENS, RUNNING, DONE, TICK
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for a prescaled two-digit stopwatch.
// Counts TENS:ONES up to TENS_MAX:ONES_MAX, then parks in DONE.
module stopwatch_ctrl #(
  parameter int PRESCALE = 4,
  parameter int ONES_MAX = 9,
  parameter int TENS_MAX = 5
) (
  input  logic CLK,
  input  logic RST,
  stopwatch_ctrl_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          tick;
  logic          ones_top;
  logic          tens_top;

  assign tick     = (state_q == S_RUN) &&
                    (presc_q == PW'(PRESCALE - 1));
  assign ones_top = (ones_q == 4'(ONES_MAX));
  assign tens_top = (tens_q == 4'(TENS_MAX));

  // Next-state, prescaler and digit update; CLEAR > STOP > START.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.CLEAR) begin
          presc_d = '0;
          ones_d  = '0;
          tens_d  = '0;
        end else if (bus.START) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.CLEAR) begin
          state_d = S_IDLE;
          presc_d = '0;
          ones_d  = '0;
          tens_d  = '0;
        end else if (tick) begin
          presc_d = '0;
          if (ones_top && tens_top) begin
            state_d = S_DONE;
          end else begin
            if (ones_top) begin
              ones_d = '0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
            if (bus.STOP) state_d = S_PAUSE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          if (bus.STOP) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (bus.CLEAR) begin
          state_d = S_IDLE;
          presc_d = '0;
          ones_d  = '0;
          tens_d  = '0;
        end else if (bus.START) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.CLEAR) begin
          state_d = S_IDLE;
          presc_d = '0;
          ones_d  = '0;
          tens_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        ones_d  = '0;
        tens_d  = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
    end
  end

  assign bus.ONES    = ones_q;
  assign bus.TENS    = tens_q;
  assign bus.RUNNING = (state_q == S_RUN);
  assign bus.DONE    = (state_q == S_DONE);
  assign bus.TICK    = tick;

endmodule
